// File: rtl/serial_mlane.sv
// Buffered parallel-to-serial converter: a small word FIFO feeds a shifter that emits
// 1, 2 or 4 bits per beat, with the lane width and bit order captured for each word.
module serial_mlane #(
    parameter int WSIZE = 8,
    parameter int DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic                   wr_vld,
    input  logic [WSIZE-1:0]       wr_data,
    input  logic                   wr_last,
    input  logic [1:0]             lane_mode,
    input  logic                   msb_first,
    output logic                   wr_ready,
    output logic [$clog2(DEPTH):0] wr_count,
    input  logic                   rd_en,
    output logic                   rd_vld,
    output logic [3:0]             rd_data,
    output logic                   word_end,
    output logic                   rd_last,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(WSIZE);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    function automatic logic [2:0] lane_step(input logic [1:0] mode);
        case (mode)
            2'd1:    return 3'd2;
            2'd2:    return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    function automatic logic [CW-1:0] last_beat(input logic [1:0] mode);
        case (mode)
            2'd1:    return CW'(WSIZE / 2 - 1);
            2'd2:    return CW'(WSIZE / 4 - 1);
            default: return CW'(WSIZE - 1);
        endcase
    endfunction

    // MSB-first words shift left and emit their top bits; LSB-first words shift right
    // and emit their bottom bits, so lane j always carries the j-th bit of the group.
    function automatic logic [3:0] beat_bits(input logic [3:0] top4, input logic [3:0] low4,
                                             input logic [1:0] mode, input logic msb);
        logic [3:0] b;
        case (mode)
            2'd1:    b = msb ? {2'b00, top4[3:2]} : {2'b00, low4[1:0]};
            2'd2:    b = msb ? top4 : low4;
            default: b = msb ? {3'b000, top4[3]} : {3'b000, low4[0]};
        endcase
        return b;
    endfunction

    logic [WSIZE-1:0] mem_data [DEPTH];
    logic [1:0]       mem_mode [DEPTH];
    logic [DEPTH-1:0] mem_last;
    logic [DEPTH-1:0] mem_msb;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    state_t           state_q;
    state_t           state_d;
    logic [WSIZE-1:0] sh;
    logic [1:0]       sh_mode;
    logic             sh_msb;
    logic             sh_last;
    logic [CW-1:0]    beat_cnt;

    logic push;
    logic pop;
    logic advance;

    assign wr_ready = (count < DEPTH_C);
    assign wr_count = count;
    assign push     = wr_vld && wr_ready;
    assign rd_vld   = (state_q == SHIFT);
    assign word_end = rd_vld && (beat_cnt == last_beat(sh_mode));
    assign rd_last  = word_end && sh_last;
    assign rd_data  = rd_vld ? beat_bits(sh[WSIZE-1 -: 4], sh[3:0], sh_mode, sh_msb) : 4'b0000;
    assign empty    = (count == '0) && !rd_vld;

    // Final beat with a word waiting reloads in the same cycle, so there is no bubble.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (rd_en) begin
                    if (word_end) begin
                        if (count != '0) pop = 1'b1;
                        else             state_d = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (pop)          beat_cnt <= '0;
            else if (advance) beat_cnt <= beat_cnt + 1'b1;
        end
    end

    // Data path carries no reset: every output it feeds is gated by rd_vld.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_data[wr_ptr] <= wr_data;
            mem_mode[wr_ptr] <= lane_mode;
            mem_last[wr_ptr] <= wr_last;
            mem_msb[wr_ptr]  <= msb_first;
        end
        if (pop) begin
            sh      <= mem_data[rd_ptr];
            sh_mode <= mem_mode[rd_ptr];
            sh_last <= mem_last[rd_ptr];
            sh_msb  <= mem_msb[rd_ptr];
        end else if (advance) begin
            sh <= sh_msb ? (sh << lane_step(sh_mode)) : (sh >> lane_step(sh_mode));
        end
    end

endmodule

// File: doc/serial_mlane.md
SERIAL_MLANE -- requirements
Module: serial_mlane

Interface
REQ-001 SHALL have parameter WSIZE, default 8: parallel word width in bits; a multiple of 4, at least 4.
REQ-002 SHALL have parameter DEPTH, default 2: input word buffer depth; a power of 2, at least 2.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port wr_vld, input, 1 bit: write request for a word.
REQ-006 SHALL have port wr_data, input, WSIZE bits: parallel word.
REQ-007 SHALL have port wr_last, input, 1 bit: tags the word as the final word of a transaction.
REQ-008 SHALL have port lane_mode, input, 2 bits: 0 = x1, 1 = x2, 2 = x4, 3 = reserved and treated as x1; sampled per word.
REQ-009 SHALL have port msb_first, input, 1 bit: bit order of the word; sampled per word.
REQ-010 SHALL have port wr_ready, output, 1 bit: the buffer can accept a word.
REQ-011 SHALL have port wr_count, output, clog2(DEPTH)+1 bits: number of buffered words, shifter excluded.
REQ-012 SHALL have port rd_en, input, 1 bit: consumer takes the current beat.
REQ-013 SHALL have port rd_vld, output, 1 bit: rd_data holds a valid beat.
REQ-014 SHALL have port rd_data, output, 4 bits: serial beat; unused lanes are driven 0.
REQ-015 SHALL have port word_end, output, 1 bit: the current beat is the final beat of a word.
REQ-016 SHALL have port rd_last, output, 1 bit: the current beat is the final beat of a word tagged wr_last.
REQ-017 SHALL have port empty, output, 1 bit: the buffer is empty and the shifter is idle.

Function
REQ-018 A write SHALL be accepted when wr_vld and wr_ready are both high; the word, wr_last, lane_mode and msb_first are stored together as one buffer entry.
REQ-019 wr_ready SHALL equal (wr_count < DEPTH) from registered state only, with no combinational path from rd_en; wr_vld while wr_ready is low SHALL be ignored.
REQ-020 Shifter FSM SHALL have two states: IDLE and SHIFT.
- IDLE -> SHIFT when the buffer is non-empty (pop and load).
- SHIFT -> IDLE on acceptance of the final beat while the buffer is empty.
- On acceptance of the final beat while the buffer is non-empty, the next word SHALL load in the same cycle, leaving no bubble.
REQ-021 A beat SHALL be accepted when rd_vld and rd_en are both high; rd_en while rd_vld is low SHALL be ignored.
REQ-022 rd_vld SHALL be high exactly in SHIFT; rd_data, word_end and rd_last SHALL hold steady while rd_vld is high and rd_en is low.
REQ-023 Beats per word SHALL be WSIZE, WSIZE/2 or WSIZE/4 for x1, x2 and x4; the beat counter SHALL be sized for WSIZE beats.
REQ-024 Beat order with msb_first = 1: word bits are emitted from bit WSIZE-1 downward; within a beat the higher-indexed word bit goes on the higher lane.
- x1: rd_data[0].
- x2: rd_data[1:0].
- x4: rd_data[3:0].
REQ-025 Beat order with msb_first = 0: word bits are emitted from bit 0 upward; within a beat word bit k+j goes on lane j.
REQ-026 word_end SHALL be high only on the final beat of each word; rd_last SHALL equal word_end AND the word's stored wr_last.
REQ-027 Latency: a word written at edge N into an empty block SHALL present its first beat with rd_vld high after edge N+1.
REQ-028 Simultaneous write and pop SHALL leave wr_count unchanged; buffer pointers SHALL wrap modulo DEPTH.
REQ-029 Changing lane_mode or msb_first mid-word SHALL NOT affect words already accepted.

Reset
REQ-030 While rst_n is low, regardless of clock: rd_vld=0, rd_data=0, word_end=0, rd_last=0, wr_count=0, wr_ready=1, empty=1, FSM=IDLE, pointers=0.
REQ-031 Reset mid-word SHALL discard the partial word and all buffered words; the first write after release SHALL behave as in REQ-027.

Verification (WSIZE=8, DEPTH=2)
REQ-032 x1, msb_first=1, write 0xA5, rd_en=1 -> rd_data[0] = 1,0,1,0,0,1,0,1; rd_data[3:1]=0; word_end on the 8th beat only.
REQ-033 x4, msb_first=0, write 0x3C, rd_en=1 -> beats 4'hC, 4'h3; word_end on the 2nd beat.
REQ-034 x2, msb_first=1, write 0xB4 with wr_last=1 -> beats 2,3,1,0; rd_last and word_end high on the 4th beat only.
REQ-035 rd_en=0, write 0x11, 0x22, 0x33, 0x44 on consecutive cycles -> 0x11 loads into the shifter, 0x22 and 0x33 are buffered, wr_ready is low after 0x33 and 0x44 is dropped; with rd_en=1 the output stream is 0x11, 0x22, 0x33 only, then empty=1.
REQ-036 x4, rd_en held at 1, back-to-back writes 0x5A then 0x96 with msb_first=1 -> rd_vld high for 4 consecutive cycles with beats 5, A, 9, 6.
REQ-037 Assert rst_n low during beat 3 of an x1 word -> all outputs take their REQ-030 values immediately; after release, a write of 0xFF yields 8 beats of 1.
